// File: rtl/register_file_mp.sv
// Multi-port register file: one write port with same-cycle bypass, optional hardwired-zero entry 0,
// and a sequential bulk-clear engine. Optional even parity per entry under REGFILE_PARITY_EN.
// Reads are zero-latency (combinational). Writes land on the next edge. Writes during a clear are dropped and flagged.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     par_inject,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     wr_dropped,
  output logic [NUM_RD-1:0]        parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_zero_hit;
  logic              wr_en;

  assign clear_busy  = (state == CLEAR);
  assign wr_zero_hit = (ZERO_REG != 0) && (write_reg == '0);
  assign wr_en       = reg_write && !clear_busy && !wr_zero_hit;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == {ADDR_W{1'b1}}) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      wr_dropped <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      wr_dropped <= reg_write && clear_busy;
    end
  end

  // The clear engine owns the array while busy; writeback is locked out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear_busy) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      mem[write_reg] <= write_data;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_mem[i] <= 1'b0;
      end
    end else if (clear_busy) begin
      par_mem[ptr] <= 1'b0;
    end else if (wr_en) begin
      par_mem[write_reg] <= (^write_data) ^ par_inject;
    end
  end
`else
  logic unused_par_inject;
  assign unused_par_inject = par_inject;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_zero;
    logic              rd_byp;

    assign rd_addr = read_reg[k*ADDR_W +: ADDR_W];
    assign rd_zero = (ZERO_REG != 0) && (rd_addr == '0);
    assign rd_byp  = wr_en && (write_reg == rd_addr);

    assign read_data[k*DATA_W +: DATA_W] = rd_zero ? '0 :
                                           rd_byp  ? write_data :
                                                     mem[rd_addr];
`ifdef REGFILE_PARITY_EN
    // Parity is checked against stored contents only, never the bypass value.
    assign parity_err[k] = !rd_zero && ((^mem[rd_addr]) != par_mem[rd_addr]);
`else
    assign parity_err[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: reset, write/bypass, zero register, bulk clear, reset mid-clear, parity.
module tb_register_file_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
`ifdef REGFILE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     reg_write;
  logic [ADDR_W-1:0]        write_reg;
  logic [DATA_W-1:0]        write_data;
  logic                     par_inject;
  logic [NUM_RD*ADDR_W-1:0] read_reg;
  logic                     clear_req;
  logic [NUM_RD*DATA_W-1:0] read_data, read_data0;
  logic                     clear_busy, clear_busy0;
  logic                     wr_dropped, wr_dropped0;
  logic [NUM_RD-1:0]        parity_err, parity_err0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .par_inject(par_inject), .read_reg(read_reg),
    .read_data(read_data), .clear_req(clear_req), .clear_busy(clear_busy),
    .wr_dropped(wr_dropped), .parity_err(parity_err)
  );

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .par_inject(par_inject), .read_reg(read_reg),
    .read_data(read_data0), .clear_req(clear_req), .clear_busy(clear_busy0),
    .wr_dropped(wr_dropped0), .parity_err(parity_err0)
  );

  wire [DATA_W-1:0] rd0  = read_data[DATA_W-1:0];
  wire [DATA_W-1:0] rd1  = read_data[2*DATA_W-1:DATA_W];
  wire [DATA_W-1:0] rd0z = read_data0[DATA_W-1:0];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    read_reg = {a1, a0};
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic inj);
    reg_write = 1'b1; write_reg = a; write_data = d; par_inject = inj;
    tick;
    reg_write = 1'b0; par_inject = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
    par_inject = 1'b0; clear_req = 1'b0; read_reg = '0;
    repeat (3) tick;
    reset_n = 1'b1;
    set_rd(5'd31, 5'd7);
    #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rd0 got %h exp %h", rd0, 32'h0); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd1, 32'h0); end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", clear_busy); end
    checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got %b exp 0", wr_dropped); end
  endtask

  task automatic test_write_bypass;
    tick;
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
    set_rd(5'd5, 5'd6);
    #1;
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd0 got %h exp %h", rd0, 32'hDEADBEEF); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL bypass_other got %h exp %h", rd1, 32'h0); end
    tick;
    reg_write = 1'b0;
    #1;
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_commit got %h exp %h", rd0, 32'hDEADBEEF); end
  endtask

  task automatic test_back_to_back;
    tick;
    set_rd(5'd10, 5'd11);
    reg_write = 1'b1; write_reg = 5'd10; write_data = 32'hA0A0A0A0;
    #1;
    checks++; if (rd0 !== 32'hA0A0A0A0) begin errors++; $display("FAIL b2b_byp0 got %h exp %h", rd0, 32'hA0A0A0A0); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL b2b_old1 got %h exp %h", rd1, 32'h0); end
    tick;
    write_reg = 5'd11; write_data = 32'hB1B1B1B1;
    #1;
    checks++; if (rd0 !== 32'hA0A0A0A0) begin errors++; $display("FAIL b2b_arr0 got %h exp %h", rd0, 32'hA0A0A0A0); end
    checks++; if (rd1 !== 32'hB1B1B1B1) begin errors++; $display("FAIL b2b_byp1 got %h exp %h", rd1, 32'hB1B1B1B1); end
    tick;
    reg_write = 1'b0;
    #1;
    checks++; if (rd1 !== 32'hB1B1B1B1) begin errors++; $display("FAIL b2b_arr1 got %h exp %h", rd1, 32'hB1B1B1B1); end
  endtask

  task automatic test_zero_reg;
    tick;
    set_rd(5'd0, 5'd0);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678;
    #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL zero_byp got %h exp %h", rd0, 32'h0); end
    checks++; if (rd0z !== 32'h12345678) begin errors++; $display("FAIL nozero_byp got %h exp %h", rd0z, 32'h12345678); end
    tick;
    reg_write = 1'b0;
    #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL zero_after got %h exp %h", rd0, 32'h0); end
    checks++; if (rd0z !== 32'h12345678) begin errors++; $display("FAIL nozero_after got %h exp %h", rd0z, 32'h12345678); end
    checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL zero_dropped got %b exp 0", wr_dropped); end
  endtask

  task automatic test_bulk_clear;
    int cyc;
    logic [DATA_W-1:0] exp1;
    tick;
    for (int a = 1; a < 32; a++) do_write(a[ADDR_W-1:0], DATA_W'(a), 1'b0);
    set_rd(5'd31, 5'd3);
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    cyc = 0;
    #1;
    while (clear_busy === 1'b1 && cyc < 100) begin
      exp1 = (cyc <= 3) ? 32'd3 : 32'd0;
      checks++; if (rd0 !== 32'd31) begin errors++; $display("FAIL clr_rd31 cyc %0d got %h exp %h", cyc, rd0, 32'd31); end
      checks++; if (rd1 !== exp1) begin errors++; $display("FAIL clr_rd3 cyc %0d got %h exp %h", cyc, rd1, exp1); end
      if (cyc == 6) begin
        checks++; if (wr_dropped !== 1'b1) begin errors++; $display("FAIL clr_dropped got %b exp 1", wr_dropped); end
      end
      if (cyc == 7) begin
        checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL clr_dropped_clr got %b exp 0", wr_dropped); end
      end
      @(posedge clk); #1;
      cyc++;
      clear_req  = (cyc == 10);
      reg_write  = (cyc == 5);
      write_reg  = 5'd3;
      write_data = 32'h55;
      #1;
    end
    reg_write = 1'b0; clear_req = 1'b0;
    #1;
    checks++; if (cyc !== 32) begin errors++; $display("FAIL clr_len got %0d exp %0d", cyc, 32); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL clr_rd31_end got %h exp %h", rd0, 32'h0); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL clr_rd3_end got %h exp %h", rd1, 32'h0); end
  endtask

  task automatic test_reset_mid_clear;
    int cyc;
    int bad;
    tick;
    do_write(5'd20, 32'd20, 1'b0);
    do_write(5'd31, 32'd31, 1'b0);
    set_rd(5'd20, 5'd31);
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    repeat (12) tick;
    #1;
    checks++; if (clear_busy !== 1'b1 || rd0 !== 32'd20) begin
      errors++; $display("FAIL mid_pre got busy %b rd %h exp busy 1 rd %h", clear_busy, rd0, 32'd20);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async got %b exp 0", clear_busy); end
    tick;
    reset_n = 1'b1;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      set_rd(a[ADDR_W-1:0], 5'd0);
      #1;
      if (rd0 !== 32'h0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_all_zero got %0d nonzero exp 0", bad); end
    tick;
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    cyc = 0;
    #1;
    while (clear_busy === 1'b1 && cyc < 100) begin
      tick;
      cyc++;
    end
    checks++; if (cyc !== 32) begin errors++; $display("FAIL mid_restart_len got %0d exp %0d", cyc, 32); end
  endtask

  task automatic test_parity;
    int cyc;
    int bad;
    logic exp_p;
    tick;
    set_rd(5'd9, 5'd0);
    do_write(5'd9, 32'h1, 1'b1);
    #1;
    exp_p = PAR;
    checks++; if (parity_err[0] !== exp_p) begin errors++; $display("FAIL par_inject got %b exp %b", parity_err[0], exp_p); end
    checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL par_data got %h exp %h", rd0, 32'h1); end
    do_write(5'd9, 32'h1, 1'b0);
    #1;
    checks++; if (parity_err[0] !== 1'b0) begin errors++; $display("FAIL par_clean got %b exp 0", parity_err[0]); end
    do_write(5'd9, 32'h7, 1'b1);
    do_write(5'd0, 32'h3, 1'b1);
    #1;
    checks++; if (parity_err[1] !== 1'b0) begin errors++; $display("FAIL par_zero_reg got %b exp 0", parity_err[1]); end
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    cyc = 0;
    #1;
    while (clear_busy === 1'b1 && cyc < 100) begin
      tick;
      cyc++;
    end
    checks++; if (cyc !== 32) begin errors++; $display("FAIL par_clr_len got %0d exp %0d", cyc, 32); end
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      set_rd(a[ADDR_W-1:0], a[ADDR_W-1:0]);
      #1;
      if (parity_err !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL par_after_clear got %0d bad exp 0", bad); end
  endtask

  initial begin
    test_reset;
    test_write_bypass;
    test_back_to_back;
    test_zero_reg;
    test_bulk_clear;
    test_reset_mid_clear;
    test_parity;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
